// File: rtl/nv_onehot_clk_pkg.sv
// rtl/nv_onehot_clk_pkg.sv - shared types, widths and one-hot decode for the clock-enable sequencer
package nv_onehot_clk_pkg;

  typedef enum logic [2:0] {
    FUNC,
    GAP_IN,
    ONE,
    GAP_STEP,
    GAP_OUT
  } state_e;

  localparam int GAP_W  = 4;
  localparam int MAX_CH = 16;

  function automatic logic [MAX_CH-1:0] onehot_dec(input logic [31:0] idx);
    logic [MAX_CH-1:0] one;
    one = MAX_CH'(1);
    return one << idx;
  endfunction

endpackage

// File: rtl/nv_onehot_gap_cnt.sv
// rtl/nv_onehot_gap_cnt.sv - loadable down-counter with zero flag, used for gap and dwell timing
module nv_onehot_gap_cnt #(
  parameter int W = 4
) (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/nv_onehot_clk_en_seq.sv
// rtl/nv_onehot_clk_en_seq.sv - registered clock-gate enables with DFT one-hot sequencing and gapped hand-offs
// Optional dwell-timer auto-step enabled by defining NV_ONEHOT_CLK_AUTO_STEP_EN.
module nv_onehot_clk_en_seq
  import nv_onehot_clk_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int CH_W      = 4,
  parameter int GAP_CYC   = 2,
  parameter int DWELL_CYC = 64
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              one_hot_enable,
  input  logic              step,
  input  logic [NUM_CH-1:0] func_en,
  output logic [NUM_CH-1:0] clk_en,
  output logic [CH_W-1:0]   active_ch,
  output logic              in_gap,
  output logic              wrap
);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] clk_en_q, clk_en_d;
  logic [CH_W-1:0]   active_ch_q, active_ch_d, ch_nxt;
  logic              in_gap_q, in_gap_d;
  logic              wrap_q, wrap_d;
  logic              gap_load, gap_dec, gap_done;
  logic              step_int;
  logic [NUM_CH-1:0] cur_mask, nxt_mask;

  assign ch_nxt   = (active_ch_q == CH_W'(NUM_CH - 1)) ? '0 : active_ch_q + CH_W'(1);
  assign cur_mask = NUM_CH'(onehot_dec(32'(active_ch_q)));
  assign nxt_mask = NUM_CH'(onehot_dec(32'(ch_nxt)));
  assign gap_dec  = (state_q == GAP_IN) || (state_q == GAP_STEP) || (state_q == GAP_OUT);

  nv_onehot_gap_cnt #(.W(GAP_W)) u_gap_cnt (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .load            (gap_load),
    .load_val        (GAP_W'(GAP_CYC - 1)),
    .dec             (gap_dec),
    .done            (gap_done)
  );

`ifdef NV_ONEHOT_CLK_AUTO_STEP_EN
  localparam int DW_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  logic dwell_load, dwell_done;

  // Reloaded on every entry to ONE so each channel gets a full dwell.
  assign dwell_load = (state_d == ONE) && (state_q != ONE);
  assign step_int   = step | ((state_q == ONE) & dwell_done);

  nv_onehot_gap_cnt #(.W(DW_W)) u_dwell_cnt (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .load            (dwell_load),
    .load_val        (DW_W'(DWELL_CYC - 1)),
    .dec             (state_q == ONE),
    .done            (dwell_done)
  );
`else
  assign step_int = step;
`endif

  always_comb begin
    state_d     = state_q;
    clk_en_d    = clk_en_q;
    active_ch_d = active_ch_q;
    wrap_d      = 1'b0;
    gap_load    = 1'b0;
    case (state_q)
      FUNC: begin
        clk_en_d = func_en;
        if (one_hot_enable) begin
          state_d     = GAP_IN;
          clk_en_d    = '0;
          active_ch_d = '0;
          gap_load    = 1'b1;
        end
      end
      GAP_IN: begin
        clk_en_d = '0;
        if (!one_hot_enable) begin
          state_d  = GAP_OUT;
          gap_load = 1'b1;
        end else if (gap_done) begin
          state_d  = ONE;
          clk_en_d = cur_mask & func_en;
        end
      end
      ONE: begin
        clk_en_d = cur_mask & func_en;
        // Leaving one-hot mode takes priority over a coincident step.
        if (!one_hot_enable) begin
          state_d  = GAP_OUT;
          clk_en_d = '0;
          gap_load = 1'b1;
        end else if (step_int) begin
          state_d  = GAP_STEP;
          clk_en_d = '0;
          gap_load = 1'b1;
        end
      end
      GAP_STEP: begin
        clk_en_d = '0;
        if (!one_hot_enable) begin
          state_d  = GAP_OUT;
          gap_load = 1'b1;
        end else if (gap_done) begin
          state_d     = ONE;
          active_ch_d = ch_nxt;
          clk_en_d    = nxt_mask & func_en;
          wrap_d      = (active_ch_q == CH_W'(NUM_CH - 1));
        end
      end
      GAP_OUT: begin
        clk_en_d = '0;
        if (gap_done) begin
          active_ch_d = '0;
          if (one_hot_enable) begin
            state_d  = GAP_IN;
            gap_load = 1'b1;
          end else begin
            state_d  = FUNC;
            clk_en_d = func_en;
          end
        end
      end
      default: begin
        state_d     = FUNC;
        clk_en_d    = '1;
        active_ch_d = '0;
      end
    endcase
    in_gap_d = (state_d == GAP_IN) || (state_d == GAP_STEP) || (state_d == GAP_OUT);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q     <= FUNC;
      clk_en_q    <= '1;
      active_ch_q <= '0;
      in_gap_q    <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_en_q    <= clk_en_d;
      active_ch_q <= active_ch_d;
      in_gap_q    <= in_gap_d;
      wrap_q      <= wrap_d;
    end
  end

  assign clk_en    = clk_en_q;
  assign active_ch = active_ch_q;
  assign in_gap    = in_gap_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_nv_onehot_clk_en_seq.sv
// tb/tb_nv_onehot_clk_en_seq.sv - scoreboard bench for the one-hot clock-enable sequencer
module tb_nv_onehot_clk_en_seq;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int G  = 2;
  localparam int DW = 8;
`ifdef NV_ONEHOT_CLK_AUTO_STEP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int K_ENTER = 0;
  localparam int K_STEP  = 1;
  localparam int K_OUT   = 2;

  logic          clk = 1'b0;
  logic          rstn, ohe, step;
  logic [N-1:0]  fe;
  logic [N-1:0]  clk_en;
  logic [CW-1:0] active_ch;
  logic          in_gap, wrap;

  always #5 clk = ~clk;

  nv_onehot_clk_en_seq #(
    .NUM_CH    (N),
    .CH_W      (CW),
    .GAP_CYC   (G),
    .DWELL_CYC (DW)
  ) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .one_hot_enable  (ohe),
    .step            (step),
    .func_en         (fe),
    .clk_en          (clk_en),
    .active_ch       (active_ch),
    .in_gap          (in_gap),
    .wrap            (wrap)
  );

  typedef struct {
    logic [N-1:0]  clk_en;
    logic [CW-1:0] ch;
    logic          gap;
    logic          wrap;
    bit            seq;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: behaviour described as "in functional mode / gap cycles left / lit channel".
  bit           m_func  = 1'b1;
  int           m_gap   = 0;
  int           m_kind  = K_ENTER;
  int           m_ch    = 0;
  int           m_dwell = 0;
  logic [N-1:0] m_clk   = '1;
  bit           m_wrap  = 1'b0;

  function automatic logic [N-1:0] ch_bits(input int c, input logic [N-1:0] f);
    logic [N-1:0] one;
    one = 1;
    return f & (one << c);
  endfunction

  task automatic model_edge(input bit r, input bit o, input bit s, input logic [N-1:0] f);
    m_wrap = 1'b0;
    if (!r) begin
      m_func = 1'b1; m_gap = 0; m_ch = 0; m_clk = '1;
    end else if (m_func) begin
      if (o) begin
        m_func = 1'b0; m_gap = G; m_kind = K_ENTER; m_ch = 0; m_clk = '0;
      end else begin
        m_clk = f;
      end
    end else if (m_gap > 0) begin
      if (m_kind != K_OUT && !o) begin
        m_kind = K_OUT; m_gap = G; m_clk = '0;
      end else if (m_gap > 1) begin
        m_gap--; m_clk = '0;
      end else if (m_kind == K_OUT) begin
        m_ch = 0;
        if (o) begin
          m_kind = K_ENTER; m_gap = G; m_clk = '0;
        end else begin
          m_func = 1'b1; m_gap = 0; m_clk = f;
        end
      end else begin
        if (m_kind == K_STEP) begin
          m_ch   = (m_ch + 1) % N;
          m_wrap = (m_ch == 0);
        end
        m_gap = 0; m_dwell = 0; m_clk = ch_bits(m_ch, f);
      end
    end else begin
      if (!o) begin
        m_kind = K_OUT; m_gap = G; m_clk = '0;
      end else if (s || (AUTO && m_dwell == DW - 1)) begin
        m_kind = K_STEP; m_gap = G; m_clk = '0;
      end else begin
        m_dwell++; m_clk = ch_bits(m_ch, f);
      end
    end
  endtask

  task automatic drive(input bit r, input bit o, input bit s, input logic [N-1:0] f);
    exp_t e;
    @(negedge clk);
    rstn = r; ohe = o; step = s; fe = f;
    model_edge(r, o, s, f);
    e.clk_en = m_clk;
    e.ch     = CW'(m_ch);
    e.gap    = (m_gap > 0);
    e.wrap   = m_wrap;
    e.seq    = !m_func;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("clk_en", 32'(clk_en), 32'(mon_e.clk_en));
      chk("active_ch", 32'(active_ch), 32'(mon_e.ch));
      chk("in_gap", 32'(in_gap), 32'(mon_e.gap));
      chk("wrap", 32'(wrap), 32'(mon_e.wrap));
      if (mon_e.seq) chk("popcount_le1", 32'($countones(clk_en) <= 1), 32'd1);
    end
  end

  initial begin
    bit o;
    rstn = 1'b0; ohe = 1'b0; step = 1'b0; fe = '0;
    repeat (3) drive(0, 0, 0, 4'b0010);
    repeat (3) drive(1, 0, 0, 4'b0010);
    // enter one-hot, then walk all channels through a wrap
    repeat (5) drive(1, 1, 0, 4'b1111);
    for (int k = 0; k < N; k++) begin
      drive(1, 1, 1, 4'b1111);
      repeat (4) drive(1, 1, 0, 4'b1111);
    end
    // step coincident with leaving one-hot mode
    drive(1, 1, 1, 4'b0110);
    drive(1, 0, 1, 4'b0110);
    repeat (4) drive(1, 0, 0, 4'b0110);
    // re-request during the exit gap
    repeat (5) drive(1, 1, 0, 4'b1010);
    drive(1, 0, 0, 4'b1010);
    repeat (6) drive(1, 1, 0, 4'b1010);
    // reset while in a step gap
    drive(1, 1, 1, 4'b1111);
    drive(0, 1, 0, 4'b1111);
    repeat (2) drive(1, 0, 0, 4'b1111);
    // step every cycle with random enables
    repeat (6) drive(1, 1, 0, 4'b1111);
    repeat (100) drive(1, 1, 1, N'($urandom));
    // no external steps: dwell behaviour
    repeat (45) drive(1, 1, 0, 4'b1111);
    // random mix of everything
    o = 1'b1;
    repeat (400) begin
      if ($urandom_range(0, 19) == 0) o = !o;
      drive($urandom_range(0, 49) != 0, o, $urandom_range(0, 3) == 0, N'($urandom));
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
